// File: rtl/opl3_host_bus_master.sv
// Host-side master for the OPL3 bus port: queues register writes and status reads,
// then plays them out as timed cs_n/wr_n/rd_n cycles after an initial ic_n pulse.
module opl3_host_bus_master #(
  parameter int LGDEPTH      = 4,
  parameter int IC_CYCLES    = 16,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int ADDR_WAIT    = 4,
  parameter int DATA_WAIT    = 24
) (
  input  logic       clk_host,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_bank,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       ic_n,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [1:0] address,
  output logic [7:0] din,
  input  logic [7:0] dout
);

  localparam int DEPTH = 1 << LGDEPTH;

  typedef enum logic [3:0] {
    S_IC, S_IDLE,
    S_A_SETUP, S_A_PULSE, S_A_RECOV,
    S_D_SETUP, S_D_PULSE, S_D_RECOV,
    S_R_SETUP, S_R_PULSE, S_R_RECOV
  } state_t;

  state_t             state, state_nx;
  logic [7:0]         cnt, cnt_nx;
  logic [17:0]        fifo_mem [DEPTH];
  logic [LGDEPTH-1:0] wr_ptr, rd_ptr;
  logic [LGDEPTH:0]   fifo_cnt, fifo_cnt_nx;
  logic [17:0]        cmd_q, cmd_nx;
  logic               push, pop, fifo_full, fifo_empty;
  logic               cs_n_nx, wr_n_nx, rd_n_nx, busy_nx;
  logic [1:0]         address_nx;
  logic [7:0]         din_nx;

  assign fifo_full  = (fifo_cnt == (LGDEPTH+1)'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign cmd_ready  = !fifo_full && (state != S_IC);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == S_IDLE) && !fifo_empty;

  function automatic logic [7:0] load_val(input state_t s);
    case (s)
      S_A_SETUP, S_D_SETUP, S_R_SETUP: load_val = 8'(SETUP_CYCLES - 1);
      S_A_PULSE, S_D_PULSE, S_R_PULSE: load_val = 8'(PULSE_CYCLES - 1);
      S_A_RECOV:                       load_val = 8'(ADDR_WAIT - 1);
      S_D_RECOV, S_R_RECOV:            load_val = 8'(DATA_WAIT - 1);
      default:                         load_val = 8'd0;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    cmd_nx   = cmd_q;
    case (state)
      S_IC:      if (cnt == 8'(IC_CYCLES - 1)) state_nx = S_IDLE;
      S_IDLE: begin
        if (!fifo_empty) begin
          cmd_nx   = fifo_mem[rd_ptr];
          state_nx = fifo_mem[rd_ptr][17] ? S_R_SETUP : S_A_SETUP;
        end
      end
      S_A_SETUP: if (cnt == 8'd0) state_nx = S_A_PULSE;
      S_A_PULSE: if (cnt == 8'd0) state_nx = S_A_RECOV;
      S_A_RECOV: if (cnt == 8'd0) state_nx = S_D_SETUP;
      S_D_SETUP: if (cnt == 8'd0) state_nx = S_D_PULSE;
      S_D_PULSE: if (cnt == 8'd0) state_nx = S_D_RECOV;
      S_D_RECOV: if (cnt == 8'd0) state_nx = S_IDLE;
      S_R_SETUP: if (cnt == 8'd0) state_nx = S_R_PULSE;
      S_R_PULSE: if (cnt == 8'd0) state_nx = S_R_RECOV;
      S_R_RECOV: if (cnt == 8'd0) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase

    // The counter starts cleared out of reset, so the ic phase counts up to its limit.
    if (state == S_IC && state_nx == S_IC) cnt_nx = cnt + 8'd1;
    else if (state_nx != state)            cnt_nx = load_val(state_nx);
    else if (cnt != 8'd0)                  cnt_nx = cnt - 8'd1;
    else                                   cnt_nx = cnt;

    case ({push, pop})
      2'b10:   fifo_cnt_nx = fifo_cnt + (LGDEPTH+1)'(1);
      2'b01:   fifo_cnt_nx = fifo_cnt - (LGDEPTH+1)'(1);
      default: fifo_cnt_nx = fifo_cnt;
    endcase

    // Bus outputs follow the next state so the registers line up with the state register.
    cs_n_nx    = 1'b1;
    wr_n_nx    = 1'b1;
    rd_n_nx    = 1'b1;
    address_nx = address;
    din_nx     = din;
    case (state_nx)
      S_A_SETUP: begin cs_n_nx = 1'b0; address_nx = {cmd_nx[16], 1'b0}; din_nx = cmd_nx[15:8]; end
      S_A_PULSE: begin cs_n_nx = 1'b0; wr_n_nx = 1'b0; end
      S_D_SETUP: begin cs_n_nx = 1'b0; address_nx = {cmd_nx[16], 1'b1}; din_nx = cmd_nx[7:0]; end
      S_D_PULSE: begin cs_n_nx = 1'b0; wr_n_nx = 1'b0; end
      S_R_SETUP: begin cs_n_nx = 1'b0; address_nx = 2'b00; end
      S_R_PULSE: begin cs_n_nx = 1'b0; rd_n_nx = 1'b0; end
      default: ;
    endcase
    busy_nx = !(state_nx == S_IDLE && fifo_cnt_nx == '0);
  end

  always_ff @(posedge clk_host) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_read, cmd_bank, cmd_reg, cmd_data};
  end

  always_ff @(posedge clk_host) begin
    if (reset) begin
      state    <= S_IC;
      cnt      <= 8'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      cmd_q    <= '0;
      ic_n     <= 1'b0;
      cs_n     <= 1'b1;
      wr_n     <= 1'b1;
      rd_n     <= 1'b1;
      address  <= 2'b00;
      din      <= 8'h00;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      busy     <= 1'b1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      fifo_cnt <= fifo_cnt_nx;
      cmd_q    <= cmd_nx;
      if (push) wr_ptr <= wr_ptr + LGDEPTH'(1);
      if (pop)  rd_ptr <= rd_ptr + LGDEPTH'(1);
      ic_n     <= (state_nx != S_IC);
      cs_n     <= cs_n_nx;
      wr_n     <= wr_n_nx;
      rd_n     <= rd_n_nx;
      address  <= address_nx;
      din      <= din_nx;
      busy     <= busy_nx;
      rd_valid <= (state == S_R_PULSE) && (cnt == 8'd0);
      if (state == S_R_PULSE && cnt == 8'd0) rd_data <= dout;
    end
  end

endmodule

// File: tb/tb_opl3_host_bus_master.sv
// Bench for opl3_host_bus_master: directed commands feed a scoreboard queue that a
// bus monitor drains as write strobes and read results appear.
module tb_opl3_host_bus_master;

  localparam int PULSE = 2;

  logic       clk_host = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_read = 1'b0, cmd_bank = 1'b0;
  logic [7:0] cmd_reg = 8'h00, cmd_data = 8'h00;
  logic       cmd_ready, rd_valid, busy, ic_n, cs_n, rd_n, wr_n;
  logic [7:0] rd_data, din, dout;
  logic [1:0] address, a_d1 = 2'b00, a_d2 = 2'b00;

  logic       f_valid = 1'b0, f_read = 1'b0, f_bank = 1'b0;
  logic [7:0] f_reg = 8'h00, f_data = 8'h00, f_dout = 8'hFF;
  logic       f_ready, f_rd_valid, f_busy, f_ic_n, f_cs_n, f_rd_n, f_wr_n;
  logic [7:0] f_rd_data, f_din;
  logic [1:0] f_address;

  always #5 clk_host = ~clk_host;

  opl3_host_bus_master dut (
    .clk_host(clk_host), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_read(cmd_read), .cmd_bank(cmd_bank), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .ic_n(ic_n), .cs_n(cs_n),
    .rd_n(rd_n), .wr_n(wr_n), .address(address), .din(din), .dout(dout));

  opl3_host_bus_master #(.ADDR_WAIT(1), .DATA_WAIT(1)) dut_fast (
    .clk_host(clk_host), .reset(reset), .cmd_valid(f_valid), .cmd_ready(f_ready),
    .cmd_read(f_read), .cmd_bank(f_bank), .cmd_reg(f_reg), .cmd_data(f_data),
    .rd_valid(f_rd_valid), .rd_data(f_rd_data), .busy(f_busy), .ic_n(f_ic_n), .cs_n(f_cs_n),
    .rd_n(f_rd_n), .wr_n(f_wr_n), .address(f_address), .din(f_din), .dout(f_dout));

  // Host interface model: status byte appears two cycles after address 00 is presented.
  always @(posedge clk_host) begin
    a_d1 <= address;
    a_d2 <= a_d1;
  end
  assign dout = (a_d2 == 2'b00) ? 8'h60 : 8'hFF;

  typedef struct packed { logic rd; logic [1:0] addr; logic [7:0] data; } ev_t;
  ev_t sb[$];
  ev_t e;
  int  checks = 0, failures = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  logic       prev_wr = 1'b1, prev_rd = 1'b1;
  int         wlow = 0, rlow = 0;
  logic [1:0] hold_a = 2'b00;
  logic [7:0] hold_d = 8'h00;

  always @(negedge clk_host) begin
    if (reset) begin
      prev_wr = 1'b1;
      prev_rd = 1'b1;
    end else begin
      if (!(prev_wr && prev_rd) && (!wr_n || !rd_n))
        check("bus_hold", {address, din}, {hold_a, hold_d});
      if (!wr_n && prev_wr) begin
        if (sb.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("wr_kind", 0, e.rd);
          check("wr_addr", address, e.addr);
          check("wr_din", din, e.data);
        end
        hold_a = address; hold_d = din; wlow = 0;
      end
      if (!rd_n && prev_rd) begin
        hold_a = address; hold_d = din; rlow = 0;
      end
      if (!wr_n) wlow++;
      if (!rd_n) rlow++;
      if (wr_n && !prev_wr) check("wr_width", wlow, PULSE);
      if (rd_n && !prev_rd) check("rd_width", rlow, PULSE);
      if (rd_valid) begin
        if (sb.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("rd_kind", 1, e.rd);
          check("rd_data", rd_data, e.data);
        end
      end
      prev_wr = wr_n;
      prev_rd = rd_n;
    end
  end

  task automatic expect_cmd(input logic rd, input logic b, input logic [7:0] r, input logic [7:0] d);
    if (rd) sb.push_back('{1'b1, 2'b00, 8'h60});
    else begin
      sb.push_back('{1'b0, {b, 1'b0}, r});
      sb.push_back('{1'b0, {b, 1'b1}, d});
    end
  endtask

  task automatic send(input logic rd, input logic b, input logic [7:0] r, input logic [7:0] d);
    int n = 0;
    @(negedge clk_host);
    cmd_read = rd; cmd_bank = b; cmd_reg = r; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 500) begin @(negedge clk_host); n++; end
    if (!cmd_ready) check("send_timeout", 0, 1);
    else expect_cmd(rd, b, r, d);
    @(posedge clk_host); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin @(negedge clk_host); n++; end
    check(name, int'(n < budget), 1);
  endtask

  task automatic ic_phase(input string name);
    int n = 0;
    logic ok = 1'b1;
    while (!ic_n && n < 100) begin
      if (cmd_ready || !cs_n || !wr_n || !rd_n) ok = 1'b0;
      n++;
      @(negedge clk_host);
    end
    check({name, "_len"}, n, 16);
    check({name, "_quiet"}, ok, 1);
  endtask

  initial begin
    int n, l1, h, l2, tail, acc, sent;
    logic dropped;

    repeat (3) @(posedge clk_host);
    @(negedge clk_host);
    check("rst_busy", busy, 1);
    check("rst_ic_n", ic_n, 0);
    check("rst_strobes", {cs_n, wr_n, rd_n}, 3'b111);
    check("rst_addr_din", {address, din}, 10'h000);
    check("rst_rd", {rd_valid, rd_data}, 9'h000);
    reset = 1'b0;
    ic_phase("ic");

    // single write: 2-cycle latency, then phase timing
    send(1'b0, 1'b1, 8'hB0, 8'h2A);
    n = 0;
    do begin @(negedge clk_host); n++; end while (cs_n && n < 100);
    check("wr_latency", n, 2);
    l1 = 0; while (!cs_n && l1 < 100) begin l1++; @(negedge clk_host); end
    h  = 0; while (cs_n && h < 100)   begin h++;  @(negedge clk_host); end
    l2 = 0; while (!cs_n && l2 < 100) begin l2++; @(negedge clk_host); end
    tail = 0; while (busy && tail < 100) begin tail++; @(negedge clk_host); end
    check("wr_addr_phase", l1, 3);
    check("wr_addr_gap", h, 4);
    check("wr_data_phase", l2, 3);
    check("wr_data_gap", tail, 24);
    drain("drain_write", 200);

    send(1'b1, 1'b1, 8'h00, 8'h00);
    drain("drain_read", 200);

    // burst of 20 behind an in-flight read
    send(1'b1, 1'b0, 8'h00, 8'h00);
    n = 0;
    while (cs_n && n < 100) begin @(negedge clk_host); n++; end
    sent = 0; acc = 0; dropped = 1'b0; n = 0;
    cmd_read = 1'b0; cmd_bank = 1'b0; cmd_reg = 8'h20; cmd_data = 8'hA0; cmd_valid = 1'b1;
    while (sent < 20 && n < 3000) begin
      if (cmd_ready) begin
        expect_cmd(1'b0, cmd_bank, cmd_reg, cmd_data);
        sent++;
        if (!dropped) acc++;
      end else dropped = 1'b1;
      @(negedge clk_host);
      n++;
      cmd_bank = sent[0]; cmd_reg = 8'h20 + 8'(sent); cmd_data = 8'hA0 + 8'(sent);
    end
    cmd_valid = 1'b0;
    check("burst_accept", acc, 16);
    check("burst_sent", sent, 20);
    drain("drain_burst", 3000);

    // reset during the data-port strobe with commands queued
    send(1'b0, 1'b0, 8'h01, 8'h11);
    send(1'b0, 1'b1, 8'h02, 8'h22);
    send(1'b0, 1'b0, 8'h03, 8'h33);
    send(1'b0, 1'b1, 8'h04, 8'h44);
    n = 0;
    while (!(!wr_n && address[0]) && n < 200) begin @(negedge clk_host); n++; end
    check("dpulse_found", int'(n < 200), 1);
    reset = 1'b1;
    @(negedge clk_host);
    check("rst_mid_strobes", {cs_n, wr_n, rd_n}, 3'b111);
    check("rst_mid_ic_n", ic_n, 0);
    @(negedge clk_host);
    sb.delete();
    reset = 1'b0;
    ic_phase("ic2");
    repeat (100) @(negedge clk_host);
    check("flush_busy", busy, 0);
    check("flush_sb", sb.size(), 0);

    // short-recovery instance: 8-cycle write, 1-cycle cs_n gap
    @(negedge clk_host);
    f_read = 1'b0; f_bank = 1'b0; f_reg = 8'h40; f_data = 8'h3F; f_valid = 1'b1;
    n = 0;
    while (!f_ready && n < 100) begin @(negedge clk_host); n++; end
    @(posedge clk_host); #1;
    f_valid = 1'b0;
    n = 0;
    while (f_cs_n && n < 100) begin @(negedge clk_host); n++; end
    l1 = 0; while (!f_cs_n && l1 < 100) begin l1++; @(negedge clk_host); end
    h  = 0; while (f_cs_n && h < 100)   begin h++;  @(negedge clk_host); end
    l2 = 0; while (!f_cs_n && l2 < 100) begin l2++; @(negedge clk_host); end
    tail = 0; while (f_busy && tail < 100) begin tail++; @(negedge clk_host); end
    check("fast_gap", h, 1);
    check("fast_cost", l1 + h + l2 + tail, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
